ddr3_dfi_seq: RTL and testbench
===============================

Name: ddr3_dfi_seq

Overview:
Command sequencer directly upstream of the DDR3 DFI PHY (x16 device, 32-bit DFI data, BL8 = 4 DFI beats). It accepts one DRAM command per valid/ready handshake and drives the DFI command, write-data and read-enable signals with PHY write/read latencies applied. It enforces a per-command minimum gap and assembles the 4 read beats returned by the PHY into one 128-bit response.

Parameters:
TPHY_WRLAT, 3, cycles from WR command to first dfi_wrdata_en beat
TPHY_RDLAT, 4, cycles from RD command to first dfi_rddata_en beat
T_RCD, 6, gap after ACT, in clk cycles
T_RP, 6, gap after PRE
T_RFC, 52, gap after REF
T_MOD, 12, gap after MRS
T_ZQ, 512, gap after ZQCL
T_RD2X, 6, gap after RD; effective = max(T_RD2X, 4)
T_WR2X, 12, gap after WR; effective = max(T_WR2X, TPHY_WRLAT+5)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 MRS, 7 ZQCL
cmd_addr_i  in  15  row/column/mode address
cmd_bank_i  in  3  bank
cmd_wrdata_i  in  128  write burst; beat n = bits [32n+31:32n]
cmd_wrmask_i  in  16  byte mask; beat n = bits [4n+3:4n]
ctrl_cke_i  in  1  registered to dfi_cke_o
ctrl_reset_n_i  in  1  registered to dfi_reset_n_o
rsp_valid_o  out  1  one-cycle pulse, read burst complete
rsp_data_o  out  128  read burst; beat n = bits [32n+31:32n]
dfi_address_o  out  15;  dfi_bank_o  out  3
dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_cs_n_o  out  1 each
dfi_cke_o, dfi_reset_n_o, dfi_odt_o  out  1 each
dfi_wrdata_o  out  32;  dfi_wrdata_en_o  out  1;  dfi_wrdata_mask_o  out  4
dfi_rddata_en_o  out  1
dfi_rddata_i  in  32;  dfi_rddata_valid_i  in  1

Behaviour:
- Reset values: ras/cas/we_n=1 (NOP), cs_n=0, cke=0, reset_n=0, odt=0, address/bank=0, wrdata=0, mask=0, wrdata_en=0, rddata_en=0, rsp_valid=0, rsp_data=0, cmd_ready=0. cmd_ready rises on the first clk after reset deasserts.
- Gap counter (10 bits): cmd_ready = (gap==0) & ~rst. On accept, {ras,cas,we}_n are driven for exactly one cycle on the next edge: ACT 011, RD 101, WR 100, PRE 010, REF 001, MRS 000, ZQCL 110, NOP 111. Address and bank are registered with the command. The gap counter loads (effective gap - 1) and decrements to 0. NOP loads 0. Consecutive NOPs are accepted every cycle.
- The command cycle is cycle C. WR: wrdata_en is high for cycles C+TPHY_WRLAT .. C+TPHY_WRLAT+3. Beat n and mask n are presented in cycle C+TPHY_WRLAT+n. Write data and mask are latched at accept. The effective T_WR2X guarantees no overlap.
- RD: rddata_en is high for cycles C+TPHY_RDLAT .. +3.
- Read collector: a 2-bit beat counter stores dfi_rddata_i into slot n on each dfi_rddata_valid_i. On the 4th beat, rsp_valid pulses the next cycle with the full 128 bits, and the counter wraps to 0. Valid beats may arrive non-contiguously. Back-to-back bursts continue the count.
- dfi_rddata_valid_i with no read outstanding is still captured (no check). Verification flags it.
- Enable pipelines are shift registers and are independent of the gap counter. A new RD may be accepted while a previous burst is still in its latency pipe.
- cke and reset_n follow the ctrl inputs with 1-cycle latency. cs_n is constantly 0 out of reset.
- Mid-operation reset: all pipes, the collector and the gap counter clear immediately. Pending bursts are dropped and no rsp is produced.

Optional Feature:
DDR3_SEQ_ODT_EN: when defined, dfi_odt_o is high from cycle C of a WR through C+TPHY_WRLAT+4 inclusive, and low otherwise. When undefined, dfi_odt_o is constant 0 and the ODT logic is absent.

Decomposition:
- Package ddr3_dfi_pkg holds:
  - op codes (OP_NOP..OP_ZQCL)
  - 3-bit {ras,cas,we} encodings per op
  - BURST_BEATS=4
  - DFI_DW=32
  - effective-gap localparam functions (max)
- One sub-module, ddr3_seq_delay_line: parameterised-depth 1-bit shift register with async reset, instantiated for the wrdata_en and rddata_en pipes.

Test Plan:
- Reset: hold rst_i 5 cycles -> all outputs at reset values. cmd_ready=0 during reset, 1 on the first edge after release.
- ACT bank 2 row 0x1A5, then RD -> ras/cas/we=011 for 1 cycle, bank=2, addr=0x1A5. cmd_ready low 6 cycles. RD encoding 101 appears ≥6 cycles after ACT.
- WR with data beats 0x11111111..0x44444444, mask 0x0F00 -> wrdata_en high at C+3..C+6 with those beats in order. Mask 0x0 at beats 0, 1, 3 and 0xF at beat 2.
- RD, PHY model returns beats 0xA0..0xA3 with one idle cycle between beats 1 and 2 -> single rsp_valid pulse, rsp_data = {0xA3,0xA2,0xA1,0xA0}. rddata_en is high C+4..C+7.
- REF then ZQCL -> cmd_ready low 52 cycles after REF, then 512 cycles after ZQCL. Commands 001 then 110.
- Assert rst_i mid write burst (beat 1) -> wrdata_en drops immediately. No further beats or rsp appear, and a new WR after release behaves normally. With DDR3_SEQ_ODT_EN defined, odt is high C..C+7 and cleared by the reset.

Source files
------------

// File: rtl/ddr3_dfi_pkg.sv
// ddr3_dfi_pkg
// Shared definitions for the DDR3 DFI command sequencer: command op codes,
// {ras_n,cas_n,we_n} encodings, DFI burst geometry and a helper used to
// derive effective command gaps.
package ddr3_dfi_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ACT  = 3'd1,
        OP_RD   = 3'd2,
        OP_WR   = 3'd3,
        OP_PRE  = 3'd4,
        OP_REF  = 3'd5,
        OP_MRS  = 3'd6,
        OP_ZQCL = 3'd7
    } dfi_op_e;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] ENC_NOP  = 3'b111;
    localparam logic [2:0] ENC_ACT  = 3'b011;
    localparam logic [2:0] ENC_RD   = 3'b101;
    localparam logic [2:0] ENC_WR   = 3'b100;
    localparam logic [2:0] ENC_PRE  = 3'b010;
    localparam logic [2:0] ENC_REF  = 3'b001;
    localparam logic [2:0] ENC_MRS  = 3'b000;
    localparam logic [2:0] ENC_ZQCL = 3'b110;

    localparam int BURST_BEATS = 4;
    localparam int DFI_DW      = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [2:0] op_enc(input logic [2:0] op);
        logic [2:0] enc;
        case (op)
            OP_ACT:  enc = ENC_ACT;
            OP_RD:   enc = ENC_RD;
            OP_WR:   enc = ENC_WR;
            OP_PRE:  enc = ENC_PRE;
            OP_REF:  enc = ENC_REF;
            OP_MRS:  enc = ENC_MRS;
            OP_ZQCL: enc = ENC_ZQCL;
            default: enc = ENC_NOP;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/ddr3_seq_delay_line.sv
// ddr3_seq_delay_line
// Parameterised-depth 1-bit shift register with asynchronous reset.
// q_o is d_i delayed by DEPTH clock cycles (DEPTH >= 1).
// Ports:
//   clk_i  clock
//   rst_i  asynchronous, active-high reset (clears every stage)
//   d_i    input bit
//   q_o    delayed output
module ddr3_seq_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign sr_d = d_i;
        end else begin : g_multi
            assign sr_d = {sr_q[DEPTH-2:0], d_i};
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ddr3_dfi_seq.sv
// ddr3_dfi_seq
// Command sequencer in front of a DDR3 DFI PHY (x16, 32-bit DFI, BL8 = 4
// beats). Accepts one command per valid/ready handshake, drives DFI command
// pins for one cycle, applies write/read PHY latencies to the data enables,
// enforces a per-command minimum gap and collects 4 read beats into one
// 128-bit response.
// Optional feature macro: DDR3_SEQ_ODT_EN (drives dfi_odt_o around writes;
// when undefined dfi_odt_o is tied low).
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   cmd_valid_i/cmd_ready_o          command handshake
//   cmd_op_i/addr_i/bank_i           command op, address, bank
//   cmd_wrdata_i/cmd_wrmask_i        write burst data and byte mask
//   ctrl_cke_i/ctrl_reset_n_i        registered to dfi_cke_o/dfi_reset_n_o
//   rsp_valid_o/rsp_data_o           read burst response
//   dfi_*                            DFI PHY interface
module ddr3_dfi_seq
    import ddr3_dfi_pkg::*;
#(
    parameter int TPHY_WRLAT = 3,
    parameter int TPHY_RDLAT = 4,
    parameter int T_RCD      = 6,
    parameter int T_RP       = 6,
    parameter int T_RFC      = 52,
    parameter int T_MOD      = 12,
    parameter int T_ZQ       = 512,
    parameter int T_RD2X     = 6,
    parameter int T_WR2X     = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [2:0]   cmd_op_i,
    input  logic [14:0]  cmd_addr_i,
    input  logic [2:0]   cmd_bank_i,
    input  logic [127:0] cmd_wrdata_i,
    input  logic [15:0]  cmd_wrmask_i,
    input  logic         ctrl_cke_i,
    input  logic         ctrl_reset_n_i,
    output logic         rsp_valid_o,
    output logic [127:0] rsp_data_o,
    output logic [14:0]  dfi_address_o,
    output logic [2:0]   dfi_bank_o,
    output logic         dfi_ras_n_o,
    output logic         dfi_cas_n_o,
    output logic         dfi_we_n_o,
    output logic         dfi_cs_n_o,
    output logic         dfi_cke_o,
    output logic         dfi_reset_n_o,
    output logic         dfi_odt_o,
    output logic [31:0]  dfi_wrdata_o,
    output logic         dfi_wrdata_en_o,
    output logic [3:0]   dfi_wrdata_mask_o,
    output logic         dfi_rddata_en_o,
    input  logic [31:0]  dfi_rddata_i,
    input  logic         dfi_rddata_valid_i
);

    localparam int RD_GAP = max_int(T_RD2X, BURST_BEATS);
    localparam int WR_GAP = max_int(T_WR2X, TPHY_WRLAT + 5);

    logic         ready_en_q;
    logic [9:0]   gap_q, gap_d, gap_load;
    logic [2:0]   cmd_q, cmd_d;
    logic [14:0]  addr_q, addr_d;
    logic [2:0]   bank_q, bank_d;
    logic [127:0] wrdata_q, wrdata_d;
    logic [15:0]  wrmask_q, wrmask_d;
    logic [2:0]   wr_cnt_q, wr_cnt_d;
    logic [2:0]   rd_cnt_q, rd_cnt_d;
    logic [1:0]   wr_beat_q;
    logic         wr_en;
    logic         rd_en;
    logic         cke_q, reset_n_q;
    logic [1:0]   rd_beat_q, rd_beat_d;
    logic [95:0]  rd_buf_q, rd_buf_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [127:0] rsp_data_q, rsp_data_d;
    logic         accept;

    // ready_en_q delays cmd_ready by one edge after reset release.
    assign cmd_ready_o = ready_en_q & (gap_q == '0) & ~rst_i;
    assign accept      = cmd_valid_i & cmd_ready_o;

    always_comb begin
        case (cmd_op_i)
            OP_ACT:  gap_load = 10'(T_RCD - 1);
            OP_RD:   gap_load = 10'(RD_GAP - 1);
            OP_WR:   gap_load = 10'(WR_GAP - 1);
            OP_PRE:  gap_load = 10'(T_RP - 1);
            OP_REF:  gap_load = 10'(T_RFC - 1);
            OP_MRS:  gap_load = 10'(T_MOD - 1);
            OP_ZQCL: gap_load = 10'(T_ZQ - 1);
            default: gap_load = 10'd0;
        endcase
    end

    always_comb begin
        gap_d    = gap_q;
        cmd_d    = ENC_NOP;
        addr_d   = addr_q;
        bank_d   = bank_q;
        wrdata_d = wrdata_q;
        wrmask_d = wrmask_q;
        wr_cnt_d = (wr_cnt_q != '0) ? wr_cnt_q - 3'd1 : wr_cnt_q;
        rd_cnt_d = (rd_cnt_q != '0) ? rd_cnt_q - 3'd1 : rd_cnt_q;
        if (gap_q != '0) begin
            gap_d = gap_q - 10'd1;
        end
        if (accept) begin
            gap_d  = gap_load;
            cmd_d  = op_enc(cmd_op_i);
            addr_d = cmd_addr_i;
            bank_d = cmd_bank_i;
            if (cmd_op_i == OP_WR) begin
                wrdata_d = cmd_wrdata_i;
                wrmask_d = cmd_wrmask_i;
                wr_cnt_d = 3'(BURST_BEATS);
            end
            if (cmd_op_i == OP_RD) begin
                rd_cnt_d = 3'(BURST_BEATS);
            end
        end
    end

    // Read collector: slot n holds beat n; the 4th beat completes the burst.
    always_comb begin
        rd_beat_d   = rd_beat_q;
        rd_buf_d    = rd_buf_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        if (dfi_rddata_valid_i) begin
            rd_beat_d = rd_beat_q + 2'd1;
            if (rd_beat_q == 2'd3) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = {dfi_rddata_i, rd_buf_q};
            end else begin
                rd_buf_d[{rd_beat_q, 5'b0} +: DFI_DW] = dfi_rddata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_en_q  <= 1'b0;
            gap_q       <= '0;
            cmd_q       <= ENC_NOP;
            addr_q      <= '0;
            bank_q      <= '0;
            wrdata_q    <= '0;
            wrmask_q    <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_beat_q   <= '0;
            cke_q       <= 1'b0;
            reset_n_q   <= 1'b0;
            rd_beat_q   <= '0;
            rd_buf_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            gap_q       <= gap_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            wrdata_q    <= wrdata_d;
            wrmask_q    <= wrmask_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_beat_q   <= wr_en ? wr_beat_q + 2'd1 : wr_beat_q;
            cke_q       <= ctrl_cke_i;
            reset_n_q   <= ctrl_reset_n_i;
            rd_beat_q   <= rd_beat_d;
            rd_buf_q    <= rd_buf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // The burst counters are high C..C+3; the delay lines shift that window
    // by the PHY latency, so each enable is high for exactly 4 cycles.
    ddr3_seq_delay_line #(.DEPTH(TPHY_WRLAT)) u_wr_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (wr_cnt_q != '0),
        .q_o   (wr_en)
    );

    ddr3_seq_delay_line #(.DEPTH(TPHY_RDLAT)) u_rd_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rd_cnt_q != '0),
        .q_o   (rd_en)
    );

`ifdef DDR3_SEQ_ODT_EN
    // High from the WR command cycle through C+TPHY_WRLAT+4.
    logic [4:0] odt_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            odt_cnt_q <= '0;
        end else if (accept && (cmd_op_i == OP_WR)) begin
            odt_cnt_q <= 5'(TPHY_WRLAT + 5);
        end else if (odt_cnt_q != '0) begin
            odt_cnt_q <= odt_cnt_q - 5'd1;
        end
    end

    assign dfi_odt_o = (odt_cnt_q != '0);
`else
    assign dfi_odt_o = 1'b0;
`endif

    assign {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} = cmd_q;
    assign dfi_cs_n_o        = 1'b0;
    assign dfi_address_o     = addr_q;
    assign dfi_bank_o        = bank_q;
    assign dfi_cke_o         = cke_q;
    assign dfi_reset_n_o     = reset_n_q;
    assign dfi_wrdata_en_o   = wr_en;
    assign dfi_wrdata_o      = wr_en ? wrdata_q[{wr_beat_q, 5'b0} +: DFI_DW] : '0;
    assign dfi_wrdata_mask_o = wr_en ? wrmask_q[{wr_beat_q, 2'b0} +: 4] : '0;
    assign dfi_rddata_en_o   = rd_en;
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_data_o        = rsp_data_q;

endmodule

// File: tb/tb_ddr3_dfi_seq.sv
module tb_ddr3_dfi_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [14:0]  cmd_addr = '0;
    logic [2:0]   cmd_bank = '0;
    logic [127:0] cmd_wrdata = '0;
    logic [15:0]  cmd_wrmask = '0;
    logic         ctrl_cke = 1'b1;
    logic         ctrl_reset_n = 1'b1;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic [14:0]  dfi_address;
    logic [2:0]   dfi_bank;
    logic         ras_n, cas_n, we_n, cs_n, cke, reset_n, odt;
    logic [31:0]  wrdata;
    logic         wrdata_en;
    logic [3:0]   wrmask;
    logic         rddata_en;
    logic [31:0]  rddata = '0;
    logic         rddata_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ddr3_dfi_seq dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cmd_valid_i        (cmd_valid),
        .cmd_ready_o        (cmd_ready),
        .cmd_op_i           (cmd_op),
        .cmd_addr_i         (cmd_addr),
        .cmd_bank_i         (cmd_bank),
        .cmd_wrdata_i       (cmd_wrdata),
        .cmd_wrmask_i       (cmd_wrmask),
        .ctrl_cke_i         (ctrl_cke),
        .ctrl_reset_n_i     (ctrl_reset_n),
        .rsp_valid_o        (rsp_valid),
        .rsp_data_o         (rsp_data),
        .dfi_address_o      (dfi_address),
        .dfi_bank_o         (dfi_bank),
        .dfi_ras_n_o        (ras_n),
        .dfi_cas_n_o        (cas_n),
        .dfi_we_n_o         (we_n),
        .dfi_cs_n_o         (cs_n),
        .dfi_cke_o          (cke),
        .dfi_reset_n_o      (reset_n),
        .dfi_odt_o          (odt),
        .dfi_wrdata_o       (wrdata),
        .dfi_wrdata_en_o    (wrdata_en),
        .dfi_wrdata_mask_o  (wrmask),
        .dfi_rddata_en_o    (rddata_en),
        .dfi_rddata_i       (rddata),
        .dfi_rddata_valid_i (rddata_valid)
    );

    typedef struct {
        logic [2:0]  op;
        logic [14:0] addr;
        logic [2:0]  bank;
        logic [2:0]  enc;
        int          spacing;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of command cycle C.
    task automatic issue(input logic [2:0] op, input logic [14:0] addr, input logic [2:0] bank,
                         input logic [127:0] data, input logic [15:0] mask);
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 128'(cmd_ready), 128'd1);
        end else begin
            cmd_valid  = 1'b1;
            cmd_op     = op;
            cmd_addr   = addr;
            cmd_bank   = bank;
            cmd_wrdata = data;
            cmd_wrmask = mask;
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_op    = 3'd0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_wr_burst(input string tag, input logic [127:0] data, input logic [15:0] mask);
        for (int k = 0; k < 10; k++) begin
            logic exp_en;
            exp_en = (k >= 3) && (k <= 6);
            chk({tag, "_en"}, 128'(wrdata_en), 128'(exp_en));
            if (exp_en) begin
                chk({tag, "_data"}, 128'(wrdata), 128'(data[32*(k-3) +: 32]));
                chk({tag, "_mask"}, 128'(wrmask), 128'(mask[4*(k-3) +: 4]));
            end
`ifdef DDR3_SEQ_ODT_EN
            chk({tag, "_odt"}, 128'(odt), 128'(k <= 7));
`else
            chk({tag, "_odt"}, 128'(odt), 128'd0);
`endif
            @(negedge clk);
        end
    endtask

    logic [127:0] wr_data1;
    logic [127:0] wr_data2;
    logic [31:0]  rd_beats[6];
    logic         rd_vld[6];

    initial begin
        vecs[0] = '{3'd0, 15'h0000, 3'd0, 3'b111, 1};
        vecs[1] = '{3'd1, 15'h1A5,  3'd2, 3'b011, 6};
        vecs[2] = '{3'd2, 15'h0040, 3'd2, 3'b101, 6};
        vecs[3] = '{3'd3, 15'h0048, 3'd5, 3'b100, 12};
        vecs[4] = '{3'd4, 15'h0400, 3'd2, 3'b010, 6};
        vecs[5] = '{3'd5, 15'h0000, 3'd0, 3'b001, 52};
        vecs[6] = '{3'd6, 15'h1234, 3'd3, 3'b000, 12};
        vecs[7] = '{3'd7, 15'h0400, 3'd0, 3'b110, 512};
        wr_data1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        wr_data2 = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        rd_beats = '{32'hA0, 32'hA1, 32'h0, 32'hA2, 32'hA3, 32'h0};
        rd_vld   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset
        idle(5);
        chk("rst_ready", 128'(cmd_ready), 128'd0);
        chk("rst_cmd", 128'({ras_n, cas_n, we_n}), 128'(3'b111));
        chk("rst_cs_n", 128'(cs_n), 128'd0);
        chk("rst_cke", 128'(cke), 128'd0);
        chk("rst_reset_n", 128'(reset_n), 128'd0);
        chk("rst_odt", 128'(odt), 128'd0);
        chk("rst_addr_bank", 128'({dfi_address, dfi_bank}), 128'd0);
        chk("rst_wr", 128'({wrdata, wrmask, wrdata_en}), 128'd0);
        chk("rst_rden", 128'(rddata_en), 128'd0);
        chk("rst_rsp", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_data", rsp_data, 128'd0);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", 128'(cmd_ready), 128'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 128'(cmd_ready), 128'd1);
        chk("cke_follow", 128'({cke, reset_n}), 128'(2'b11));
        @(negedge clk);

        // Table: encoding, address/bank and command spacing for every op
        for (int v = 0; v < 8; v++) begin
            int n;
            issue(vecs[v].op, vecs[v].addr, vecs[v].bank, wr_data1, 16'h0);
            chk($sformatf("enc_op%0d", v), 128'({ras_n, cas_n, we_n}), 128'(vecs[v].enc));
            chk($sformatf("addr_op%0d", v), 128'({dfi_address, dfi_bank}),
                128'({vecs[v].addr, vecs[v].bank}));
            n = 0;
            while (!cmd_ready && n < 1000) begin
                @(negedge clk);
                n++;
                if (n == 1) chk($sformatf("one_cycle_op%0d", v), 128'({ras_n, cas_n, we_n}), 128'(3'b111));
            end
            chk($sformatf("spacing_op%0d", v), 128'(n + 1), 128'(vecs[v].spacing));
        end
        idle(12);

        // ACT then RD held valid: RD reaches the pins 6 cycles after ACT
        begin
            int k;
            issue(3'd1, 15'h1A5, 3'd2, '0, '0);
            chk("act_enc", 128'({ras_n, cas_n, we_n, dfi_bank, dfi_address}),
                128'({3'b011, 3'd2, 15'h1A5}));
            chk("act_ready_low", 128'(cmd_ready), 128'd0);
            cmd_valid = 1'b1;
            cmd_op    = 3'd2;
            k = 0;
            while ({ras_n, cas_n, we_n} != 3'b101 && k < 50) begin
                @(negedge clk);
                k++;
            end
            cmd_valid = 1'b0;
            cmd_op    = 3'd0;
            chk("act_to_rd", 128'(k), 128'd6);
        end
        idle(20);

        // WR burst with latency and mask placement
        issue(3'd3, 15'h0010, 3'd1, wr_data1, 16'h0F00);
        check_wr_burst("wr1", wr_data1, 16'h0F00);
        idle(10);

        // RD enable window and beat collection with a gap
        begin
            int pulses = 0;
            int pulse_at = -1;
            issue(3'd2, 15'h0020, 3'd1, '0, '0);
            for (int k = 0; k < 10; k++) begin
                chk("rden_win", 128'(rddata_en), 128'((k >= 4) && (k <= 7)));
                @(negedge clk);
            end
            for (int i = 0; i < 9; i++) begin
                if (rsp_valid) begin
                    pulses++;
                    pulse_at = i;
                    chk("rsp_data", rsp_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
                end
                rddata_valid = (i < 6) ? rd_vld[i] : 1'b0;
                rddata       = (i < 6) ? rd_beats[i] : 32'h0;
                @(negedge clk);
            end
            chk("rsp_pulses", 128'(pulses), 128'd1);
            chk("rsp_when", 128'(pulse_at), 128'd5);
        end

        // Reset in the middle of a write burst
        begin
            int pulses = 0;
            int en_seen = 0;
            rddata_valid = 1'b1;
            rddata = 32'hBAD0;
            @(negedge clk);
            rddata = 32'hBAD1;
            @(negedge clk);
            rddata_valid = 1'b0;
            issue(3'd3, 15'h0030, 3'd3, wr_data1, 16'h0F00);
            idle(4);
            chk("mid_beat1", 128'({wrdata_en, wrdata}), 128'({1'b1, 32'h22222222}));
            rst = 1'b1;
            #1;
            chk("mid_rst_en", 128'({wrdata_en, wrdata, wrmask}), 128'd0);
            chk("mid_rst_odt", 128'(odt), 128'd0);
            chk("mid_rst_ready", 128'(cmd_ready), 128'd0);
            idle(2);
            rst = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (wrdata_en) en_seen++;
                if (rsp_valid) pulses++;
                rddata_valid = (i == 2) || (i == 3);
                rddata       = 32'hC0 + 32'(i - 2);
                @(negedge clk);
            end
            rddata_valid = 1'b0;
            chk("post_rst_no_en", 128'(en_seen), 128'd0);
            chk("post_rst_no_rsp", 128'(pulses), 128'd0);
            rddata_valid = 1'b1;
            rddata = 32'hC2;
            @(negedge clk);
            rddata = 32'hC3;
            @(negedge clk);
            rddata_valid = 1'b0;
            chk("post_rst_rsp_valid", 128'(rsp_valid), 128'd1);
            chk("post_rst_rsp_data", rsp_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
            @(negedge clk);
            chk("post_rst_rsp_pulse", 128'(rsp_valid), 128'd0);
            issue(3'd3, 15'h0050, 3'd4, wr_data2, 16'h5A3C);
            check_wr_burst("wr2", wr_data2, 16'h5A3C);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
